list_concat_n: RTL
==================

# list_concat_n

Parametrised N-way list concatenator for the generated list-stream datapath. It presents CHANNELS producer lists as one consumer list: all elements of channel 0, then channel 1, and so on. A single end-of-list marker is emitted after the last channel is exhausted. Unlike the two-input combinational concatenator, this block has configurable width and channel count, registered handshake outputs, empty-list skipping, a sticky end-of-list state and an element counter.

## Interface
Parameters:
- WIDTH, 8, element width in bits.
- CHANNELS, 4, number of input lists; must be ≥1.
- COUNT_W, 16, width of the element counter.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  in  1  low forces the same state as reset (synchronous restart); high = run.
- in_req  out  CHANNELS  request to channel i.
- in_ack  in  CHANNELS  one-cycle ack pulse from channel i.
- in_value  in  CHANNELS*WIDTH  channel i element at [i*WIDTH +: WIDTH].
- in_value_valid  in  CHANNELS  channel i: 1 = element, 0 = end of list.
- req  in  1  consumer request.
- ack  out  1  one-cycle response pulse.
- value  out  WIDTH  element, valid while ack=1.
- value_valid  out  1  1 = element, 0 = end of concatenated list.
- channel  out  clog2(CHANNELS) (min 1)  index of the currently selected channel.
- count  out  COUNT_W  elements delivered with value_valid=1 since reset; saturates at all-ones.

## Operation
- List protocol:
  - The consumer raises req and holds it until it sees ack.
  - It then drops req for at least one cycle before the next request.
  - The producer returns ack for exactly one cycle, with value and value_valid valid in that cycle.
- FSM states: IDLE, FETCH, GAP, RESP, WAIT_LOW.
- IDLE:
  - All in_req are low.
  - If req=1 and done=1, load value_valid=0 and go to RESP.
  - If req=1 and done=0, go to FETCH.
- FETCH:
  - in_req[sel]=1; all other in_req bits are 0.
  - in_ack[sel]=1 with valid=1: latch value and valid, go to RESP.
  - in_ack[sel]=1 with valid=0 and sel<CHANNELS-1 (empty or exhausted channel): swallow the marker, sel←sel+1, go to GAP. The consumer sees nothing.
  - in_ack[sel]=1 with valid=0 and sel=CHANNELS-1: latch valid=0, set done, go to RESP.
- GAP: all in_req are low for exactly one cycle, giving the next producer a rising req edge. Then go to FETCH.
- RESP:
  - ack=1 for exactly one cycle.
  - If the latched valid=1, count increments (saturating).
  - Then go to WAIT_LOW.
- WAIT_LOW: wait for req=0, then go to IDLE.
- done is sticky. Every later request is answered with ack and value_valid=0 and no in_req activity, until reset or ready=0.
- The following inputs are ignored:
  - in_ack on non-selected channels.
  - in_ack outside FETCH.
- req dropping during FETCH is a protocol violation. The fetch still completes and the response is delivered in RESP.
- Reset or ready=0, at any time including mid-fetch:
  - Next cycle: state=IDLE, sel=0, done=0, count=0.
  - in_req=0, ack=0, value=all-ones, value_valid=0.
  - No partial response is emitted.
- CHANNELS=1 degenerates to a registered pass-through with a sticky end.

## Timing
- All outputs are decoded from registers. There is no combinational path from req or in_* to any output.
- Latency:
  - req sampled high at edge k gives in_req[sel] high in cycle k+1.
  - in_ack sampled at edge m gives ack high in cycle m+1.
- Each empty-channel skip costs 2 cycles: the swallowed ack plus GAP.
- value and value_valid hold their last latched value outside RESP.
- channel updates on the edge after the swallowed end marker.
- Reset values: in_req=0, ack=0, value={WIDTH{1}}, value_valid=0, channel=0, count=0.

## Structure
- Shared package list_stream_pkg holds:
  - state enum (IDLE, FETCH, GAP, RESP, WAIT_LOW);
  - LIST_INVALID constant (all-ones fill);
  - sel-width helper function, reused by other list blocks.
- One sub-module, list_chan_sel: a combinational index-select of in_ack, in_value and in_value_valid by sel.
- The FSM, counter and output registers stay in list_concat_n.

## Test plan
- CHANNELS=3, lists [1,2], [3], [4,5]: 6 requests → values 1,2,3,4,5 then valid=0; count=5.
- Channel 1 empty, lists [A], [], [B]:
  - responses A, B, end;
  - channel goes 0→1→2;
  - in_req[1] pulses once; GAP has in_req low for exactly 1 cycle.
- After end, 3 further requests → 3 acks with valid=0; no in_req activity.
- Reset asserted mid-FETCH with in_req[2]=1:
  - next cycle all outputs at reset values;
  - the next request fetches from channel 0.
- COUNT_W=2, 5 elements → count sticks at 3.
- Producer acks in the same cycle as in_req rises → ack exactly 1 cycle later; stray in_ack[0] while sel=1 is ignored.

Source files
------------

// File: rtl/list_stream_pkg.sv
// ---------------------------------------------------------------------------
// list_stream_pkg
//
// Purpose:
//   Shared definitions for the list-stream datapath blocks.
//   - list_state_t : request/response FSM states used by list consumers
//                    that fetch from producers on behalf of a downstream
//                    requester.
//   - LIST_INVALID : fill bit used to build the "no element" data word
//                    (all ones at any width).
//   - selWidth()   : width of a channel-select index for n channels.
//                    Never below 1, so a single-channel block still has
//                    a legal one-bit index port.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package list_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      GAP,
      RESP,
      WAIT_LOW
   } list_state_t;

   // Replicate this bit to WIDTH to get the all-ones invalid data word.
   localparam logic LIST_INVALID = 1'b1;

   function automatic int selWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/list_chan_sel.sv
// ---------------------------------------------------------------------------
// list_chan_sel
//
// Purpose:
//   Combinational selector that picks one producer channel's ack, element
//   and element-valid flag by index.  Channels other than the selected one
//   are invisible to the caller, so stray acks elsewhere are dropped here.
//
// Parameters:
//   WIDTH    - element width in bits
//   CHANNELS - number of producer channels
//   SEL_W    - width of the select index
//
// Ports:
//   i_sel          in   SEL_W            selected channel index
//   i_inAck        in   CHANNELS         per-channel ack pulses
//   i_inValue      in   CHANNELS*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   i_inValueValid in   CHANNELS         per-channel element/end flag
//   o_ack          out  1                ack of the selected channel
//   o_value        out  WIDTH            element of the selected channel
//   o_valid        out  1                element/end flag of the selected channel
// ---------------------------------------------------------------------------
module list_chan_sel
   import list_stream_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
)
(
   input  logic [SEL_W-1:0]          i_sel,
   input  logic [CHANNELS-1:0]       i_inAck,
   input  logic [CHANNELS*WIDTH-1:0] i_inValue,
   input  logic [CHANNELS-1:0]       i_inValueValid,
   output logic                      o_ack,
   output logic [WIDTH-1:0]          o_value,
   output logic                      o_valid
);

   // An out-of-range index (possible when CHANNELS is not a power of two)
   // simply selects nothing: no ack, invalid data.  Comparing against each
   // legal index avoids any out-of-bounds part-select.
   always_comb begin
      o_ack   = 1'b0;
      o_value = {WIDTH{LIST_INVALID}};
      o_valid = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (i_sel == SEL_W'(i)) begin
            o_ack   = i_inAck[i];
            o_value = i_inValue[i*WIDTH +: WIDTH];
            o_valid = i_inValueValid[i];
         end
      end
   end

endmodule

// File: rtl/list_concat_n.sv
// ---------------------------------------------------------------------------
// list_concat_n
//
// Purpose:
//   Presents CHANNELS producer lists to one consumer as a single list: all
//   elements of channel 0, then channel 1, and so on, followed by a single
//   end-of-list marker once the last channel is exhausted.  Empty or
//   exhausted channels are skipped without the consumer seeing anything.
//   After the final end marker the block answers every further request
//   with an end marker on its own, without touching the producers, until
//   reset or ready drops.  Elements delivered are counted (saturating).
//
// Parameters:
//   WIDTH    - element width in bits
//   CHANNELS - number of producer lists (>= 1)
//   COUNT_W  - width of the delivered-element counter
//
// Ports:
//   clock          in   1               rising-edge clock
//   reset          in   1               synchronous active-high reset
//   ready          in   1               low = synchronous restart, high = run
//   in_req         out  CHANNELS        request to producer channel i
//   in_ack         in   CHANNELS        one-cycle ack from producer channel i
//   in_value       in   CHANNELS*WIDTH  channel i element at [i*WIDTH +: WIDTH]
//   in_value_valid in   CHANNELS        channel i: 1 = element, 0 = end of list
//   req            in   1               consumer request (held until ack)
//   ack            out  1               one-cycle response pulse
//   value          out  WIDTH           element, valid while ack = 1
//   value_valid    out  1               1 = element, 0 = end of whole list
//   channel        out  selWidth(CH)    currently selected channel
//   count          out  COUNT_W         elements delivered since restart
//
// Every output is decoded from registers only, so nothing on req or in_*
// reaches an output in the same cycle.
// ---------------------------------------------------------------------------
module list_concat_n
   import list_stream_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int COUNT_W  = 16
)
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ready,
   output logic [CHANNELS-1:0]           in_req,
   input  logic [CHANNELS-1:0]           in_ack,
   input  logic [CHANNELS*WIDTH-1:0]     in_value,
   input  logic [CHANNELS-1:0]           in_value_valid,
   input  logic                          req,
   output logic                          ack,
   output logic [WIDTH-1:0]              value,
   output logic                          value_valid,
   output logic [selWidth(CHANNELS)-1:0] channel,
   output logic [COUNT_W-1:0]            count
);

   localparam int                SEL_W    = selWidth(CHANNELS);
   localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(CHANNELS - 1);

   list_state_t        r_state;
   logic [SEL_W-1:0]   r_sel;
   logic               r_done;
   logic [WIDTH-1:0]   r_value;
   logic               r_valid;
   logic [COUNT_W-1:0] r_count;

   list_state_t        w_nextState;
   logic [SEL_W-1:0]   w_nextSel;
   logic               w_nextDone;
   logic [WIDTH-1:0]   w_nextValue;
   logic               w_nextValid;
   logic [COUNT_W-1:0] w_nextCount;

   logic               w_selAck;
   logic [WIDTH-1:0]   w_selValue;
   logic               w_selValid;
   logic               w_restart;

   // Only the currently selected producer is ever listened to.
   list_chan_sel #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_chanSel (
      .i_sel          (r_sel),
      .i_inAck        (in_ack),
      .i_inValue      (in_value),
      .i_inValueValid (in_value_valid),
      .o_ack          (w_selAck),
      .o_value        (w_selValue),
      .o_valid        (w_selValid)
   );

   // ready low behaves exactly like reset so a stalled or reconfigured
   // pipeline can restart the concatenation from channel 0.
   assign w_restart = reset | ~ready;

   // Next-state and next-data logic.
   // FETCH waits for the selected producer only; acks arriving in any other
   // state are ignored because only FETCH looks at w_selAck.  An end marker
   // from a non-final channel is swallowed and followed by one GAP cycle so
   // the next producer sees a fresh rising edge on its request.  An end
   // marker from the final channel becomes the consumer's end marker and
   // makes the end state sticky; from then on IDLE answers directly.
   // A consumer dropping req during FETCH does not abort the fetch; the
   // result is still delivered through RESP.
   always_comb begin
      w_nextState = r_state;
      w_nextSel   = r_sel;
      w_nextDone  = r_done;
      w_nextValue = r_value;
      w_nextValid = r_valid;
      w_nextCount = r_count;

      case (r_state)
         IDLE: begin
            if (req) begin
               if (r_done) begin
                  w_nextValid = 1'b0;
                  w_nextState = RESP;
               end else begin
                  w_nextState = FETCH;
               end
            end
         end

         FETCH: begin
            if (w_selAck) begin
               if (w_selValid) begin
                  w_nextValue = w_selValue;
                  w_nextValid = 1'b1;
                  w_nextState = RESP;
               end else if (r_sel == LAST_SEL) begin
                  w_nextValid = 1'b0;
                  w_nextDone  = 1'b1;
                  w_nextState = RESP;
               end else begin
                  w_nextSel   = r_sel + SEL_W'(1);
                  w_nextState = GAP;
               end
            end
         end

         GAP: begin
            w_nextState = FETCH;
         end

         RESP: begin
            if (r_valid && (r_count != {COUNT_W{1'b1}})) begin
               w_nextCount = r_count + COUNT_W'(1);
            end
            w_nextState = WAIT_LOW;
         end

         WAIT_LOW: begin
            if (!req) begin
               w_nextState = IDLE;
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and data registers.  A restart discards any fetch in progress,
   // so no partial response can leak out afterwards.
   always_ff @(posedge clock) begin
      if (w_restart) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_done  <= 1'b0;
         r_value <= {WIDTH{LIST_INVALID}};
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         r_sel   <= w_nextSel;
         r_done  <= w_nextDone;
         r_value <= w_nextValue;
         r_valid <= w_nextValid;
         r_count <= w_nextCount;
      end
   end

   // Producer request decode: exactly the selected channel while fetching,
   // nothing otherwise (GAP in particular drives all requests low).
   always_comb begin
      in_req = '0;
      if (r_state == FETCH) begin
         for (int i = 0; i < CHANNELS; i++) begin
            in_req[i] = (r_sel == SEL_W'(i));
         end
      end
   end

   // Consumer-side outputs come straight from state and data registers;
   // value and value_valid therefore hold their last latched contents
   // outside RESP.
   assign ack         = (r_state == RESP);
   assign value       = r_value;
   assign value_valid = r_valid;
   assign channel     = r_sel;
   assign count       = r_count;

endmodule
